// File: rtl/register_file_pkg.sv
// register_file_pkg: shared sizes and data/address types for the register file slice.
package register_file_pkg;
   localparam int RF_WIDTH      = 16;
   localparam int RF_DEPTH      = 8;
   localparam int RF_ADDR_WIDTH = 3;
   typedef logic [RF_WIDTH-1:0]      rf_data_t;
   typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
endpackage

// File: rtl/register_file_entry.sv
// register_file_entry: one storage word with asynchronous clear and load enable.
module register_file_entry #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] data_q, data_d;
   always_comb data_d = ld_i ? d_i : data_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) data_q <= '0;
      else         data_q <= data_d;
   assign q_o = data_q;
endmodule

// File: rtl/register_file.sv
// register_file: 8x16 flop-based register file, single shared address, registered read data.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH      = RF_WIDTH,
   parameter int DEPTH      = RF_DEPTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WIDTH-1:0]      WrData,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic                  WrEn,
   input  logic                  RdEn,
   output logic [WIDTH-1:0]      RdData
);
   logic                   wr_go, rd_go;
   logic [DEPTH-1:0]       wr_sel;
   logic [WIDTH-1:0]       mem [DEPTH];
   logic [WIDTH-1:0]       rd_data_q, rd_data_d;
   // Simultaneous read and write is treated as a no-op, not prioritised.
   always_comb begin
      wr_go = WrEn & ~RdEn;
      rd_go = RdEn & ~WrEn;
   end
   genvar i;
   for (i = 0; i < DEPTH; i++) begin : g_entry
      assign wr_sel[i] = wr_go && (Address == ADDR_WIDTH'(i));
      register_file_entry #(.WIDTH(WIDTH)) u_entry (
         .clk_i  (CLK),
         .rst_ni (RST),
         .ld_i   (wr_sel[i]),
         .d_i    (WrData),
         .q_o    (mem[i])
      );
   end
   always_comb rd_data_d = rd_go ? mem[Address] : rd_data_q;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) rd_data_q <= '0;
      else      rd_data_q <= rd_data_d;
   assign RdData = rd_data_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array model.
module tb_register_file;
   import register_file_pkg::*;
   logic     CLK = 1'b0;
   logic     RST = 1'b0;
   rf_data_t WrData = '0;
   rf_addr_t Address = '0;
   logic     WrEn = 1'b0;
   logic     RdEn = 1'b0;
   rf_data_t RdData;
   int       vectors = 0;
   int       errors = 0;
   rf_data_t ref_mem [RF_DEPTH];
   rf_data_t ref_rd;
   always #5 CLK = ~CLK;
   register_file dut (
      .CLK     (CLK),
      .RST     (RST),
      .WrData  (WrData),
      .Address (Address),
      .WrEn    (WrEn),
      .RdEn    (RdEn),
      .RdData  (RdData)
   );
   task automatic check(input string tag, input rf_data_t obs, input rf_data_t exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cycle(input logic we, input logic re, input rf_addr_t a, input rf_data_t d,
                        input string tag);
      WrEn = we; RdEn = re; Address = a; WrData = d;
      @(posedge CLK);
      if (we && !re)      ref_mem[a] = d;
      else if (re && !we) ref_rd = ref_mem[a];
      #1 check(tag, RdData, ref_rd);
   endtask
   task automatic clear_model();
      foreach (ref_mem[k]) ref_mem[k] = '0;
      ref_rd = '0;
   endtask
   task automatic do_reset(input int hold_ns);
      #2 RST = 1'b0;
      clear_model();
      #1 check("rst_imm", RdData, 16'h0000);
      #(hold_ns) check("rst_hold", RdData, 16'h0000);
      @(negedge CLK);
      RST = 1'b1;
   endtask
   task automatic read_all(input string tag);
      for (int k = 0; k < RF_DEPTH; k++) cycle(1'b0, 1'b1, rf_addr_t'(k), $urandom(), tag);
   endtask
   initial begin
      clear_model();
      #1 check("por_rd", RdData, 16'h0000);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      // arbitrary prior contents, then a long reset landing mid-cycle
      for (int k = 0; k < RF_DEPTH; k++) cycle(1'b1, 1'b0, rf_addr_t'(k), $urandom(), "fill");
      cycle(1'b0, 1'b1, 3'd6, '0, "fill_rd");
      do_reset(3000);
      read_all("t1_sweep");
      check("t1_last", RdData, 16'h0000);
      cycle(1'b1, 1'b0, 3'd5, 16'h000B, "t2_wr");
      cycle(1'b0, 1'b1, 3'd5, '0, "t2_rd");
      check("t2_val", RdData, 16'h000B);
      cycle(1'b0, 1'b1, 3'd4, '0, "t2_other");
      check("t2_other_val", RdData, 16'h0000);
      cycle(1'b1, 1'b0, 3'd2, 16'h001F, "t3_wr");
      cycle(1'b0, 1'b1, 3'd2, '0, "t3_rd2");
      check("t3_val2", RdData, 16'h001F);
      cycle(1'b0, 1'b1, 3'd5, '0, "t3_rd5");
      check("t3_val5", RdData, 16'h000B);
      cycle(1'b0, 1'b0, 3'd1, 16'h1234, "t4_idle");
      cycle(1'b1, 1'b0, 3'd0, 16'hFFFF, "t4_wr");
      check("t4_hold", RdData, 16'h000B);
      cycle(1'b0, 1'b1, 3'd0, '0, "t4_rd");
      check("t4_val", RdData, 16'hFFFF);
      cycle(1'b1, 1'b1, 3'd3, 16'hA5A5, "t5_both");
      check("t5_hold", RdData, 16'hFFFF);
      cycle(1'b0, 1'b1, 3'd3, '0, "t5_rd");
      check("t5_val", RdData, 16'h0000);
      cycle(1'b1, 1'b0, 3'd7, 16'h7777, "t6_pre");
      WrEn = 1'b1; RdEn = 1'b0; Address = 3'd7; WrData = 16'hBEEF;
      do_reset(40);
      read_all("t6_sweep");
      cycle(1'b0, 1'b1, 3'd7, '0, "t6_rd7");
      check("t6_val", RdData, 16'h0000);
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(99) == 0) begin
            WrEn = $urandom_range(1); RdEn = $urandom_range(1);
            Address = rf_addr_t'($urandom()); WrData = $urandom();
            do_reset($urandom_range(60, 5));
         end else begin
            cycle($urandom_range(2) == 0, $urandom_range(2) == 0, rf_addr_t'($urandom()),
                  rf_data_t'($urandom()), "rand");
         end
      end
      read_all("final_sweep");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
